// File: rtl/cpu_led_blink_pio_if.sv
// Avalon-MM slave bus bundle for the LED/output PIO.
// The CPU data master drives address, select, strobe and write data.
// The PIO returns combinational read data.
interface cpu_led_blink_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/cpu_led_blink_pio.sv
// Parametrised output port with atomic set/clear/toggle strobes.
// A per-bit hardware blink mode is driven by a programmable prescaler.
// The port is a zero-wait-state slave: writes land on the sampling edge,
// out_port follows one cycle later, and readdata is a pure decode of address.
module cpu_led_blink_pio #(
    parameter int unsigned      WIDTH       = 10,
    parameter int unsigned      PRESC_W     = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                clk,
    input  logic                reset,
    cpu_led_blink_pio_if.slave  bus,
    output logic [WIDTH-1:0]    out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_SET      = 3'd3;
    localparam logic [2:0] ADDR_CLEAR    = 3'd4;
    localparam logic [2:0] ADDR_TOGGLE   = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    logic               wr_en;
    logic               period_wr;
    logic [WIDTH-1:0]   wd_w;
    logic [PRESC_W-1:0] wd_p;

    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   data_d;
    logic [WIDTH-1:0]   blink_en_q;
    logic [WIDTH-1:0]   blink_en_d;
    logic [PRESC_W-1:0] period_q;
    logic [PRESC_W-1:0] period_d;
    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;
    logic               phase_q;
    logic               phase_d;
    logic [WIDTH-1:0]   out_p1;

    // Upper write-data bits beyond WIDTH/PRESC_W are deliberately dropped.
    logic               unused_wd;

    assign wr_en     = bus.chipselect && !bus.write_n;
    assign period_wr = wr_en && (bus.address == ADDR_PERIOD);
    assign wd_w      = bus.writedata[WIDTH-1:0];
    assign wd_p      = bus.writedata[PRESC_W-1:0];
    assign unused_wd = ^bus.writedata;

    // Register-file next state: plain writes and atomic read-modify-write strobes.
    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_d     = wd_w;
                ADDR_BLINK_EN: blink_en_d = wd_w;
                ADDR_PERIOD:   period_d   = wd_p;
                ADDR_SET:      data_d     = data_q | wd_w;
                ADDR_CLEAR:    data_d     = data_q & ~wd_w;
                ADDR_TOGGLE:   data_d     = data_q ^ wd_w;
                default:       ;
            endcase
        end
    end

    // Prescaler next state: a PERIOD write restarts the engine and beats an expiry.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr) begin
            cnt_d   = wd_p;
            phase_d = 1'b1;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == '0) begin
            cnt_d   = period_q;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - PRESC_W'(1);
        end
    end

    // Register file and blink engine state; reset wins over any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b1;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
        end
    end

    // ---- stage p1: output pins, one cycle behind the register file ----
    // Blinking bits are blanked while phase is low; others follow DATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_p1 <= RESET_VALUE;
        end else begin
            out_p1 <= data_q & ~(blink_en_q & {WIDTH{~phase_q}});
        end
    end

    assign out_port = out_p1;

    // Read decode; chipselect qualification is left to the fabric.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:     bus.readdata = 32'(data_q);
            ADDR_BLINK_EN: bus.readdata = 32'(blink_en_q);
            ADDR_PERIOD:   bus.readdata = 32'(period_q);
            ADDR_STATUS:   bus.readdata = {30'd0, (period_q != '0), phase_q};
            default:       bus.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cpu_led_blink_pio.sv
// Randomised bench for cpu_led_blink_pio against a behavioural model.
// The model tracks phase as a function of edges elapsed since the last
// PERIOD load; a second narrow instance covers width masking.
module tb_cpu_led_blink_pio;

    localparam logic [9:0] RV = 10'h2A5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_led_blink_pio_if bus ();
    cpu_led_blink_pio_if bus4 ();
    logic [9:0] out_port;
    logic [3:0] out_port4;

    cpu_led_blink_pio #(.WIDTH(10), .PRESC_W(24), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset), .bus(bus), .out_port(out_port)
    );

    cpu_led_blink_pio #(.WIDTH(4), .PRESC_W(8), .RESET_VALUE(4'h0)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .out_port(out_port4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    logic [9:0]  m_data;
    logic [9:0]  m_en;
    logic [9:0]  m_out;
    logic [23:0] m_p;
    int unsigned m_age;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic m_phase();
        if (m_p == 24'd0) return 1'b1;
        return ((m_age / (32'(m_p) + 32'd1)) % 32'd2) == 32'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd1:    return 32'(m_en);
            3'd2:    return 32'(m_p);
            3'd6:    return {30'd0, (m_p != 24'd0), m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        logic wr;
        wr = cs && !wn;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
        @(posedge clk);
        m_out = m_data & ~(m_en & {10{~m_phase()}});
        m_age++;
        if (wr) begin
            case (a)
                3'd0: m_data = wd[9:0];
                3'd1: m_en   = wd[9:0];
                3'd2: begin m_p = wd[23:0]; m_age = 0; end
                3'd3: m_data = m_data | wd[9:0];
                3'd4: m_data = m_data & ~wd[9:0];
                3'd5: m_data = m_data ^ wd[9:0];
                default: ;
            endcase
        end
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        check("out_port", 32'(out_port), 32'(m_out));
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    task automatic rd(input logic [2:0] a, input string tag);
        bus.address = a;
        #1;
        check(tag, bus.readdata, m_read(a));
    endtask

    task automatic rdc(input logic [2:0] a, input string tag, input logic [31:0] exp);
        bus.address = a;
        #1;
        check(tag, bus.readdata, exp);
    endtask

    task automatic do_reset(input int n);
        bus.chipselect  = 1'b0;
        bus.write_n     = 1'b1;
        bus4.chipselect = 1'b0;
        bus4.write_n    = 1'b1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        m_data = RV;
        m_en   = '0;
        m_p    = '0;
        m_age  = 0;
        m_out  = RV;
        #1 reset = 1'b0;
        check("reset_out", 32'(out_port), 32'(m_out));
    endtask

    task automatic wr4(input logic [2:0] a, input logic [31:0] wd);
        bus4.chipselect = 1'b1;
        bus4.write_n    = 1'b0;
        bus4.address    = a;
        bus4.writedata  = wd;
        @(posedge clk);
        #1;
        bus4.chipselect = 1'b0;
        bus4.write_n    = 1'b1;
    endtask

    task automatic rd4(input logic [2:0] a, input string tag, input logic [31:0] exp);
        bus4.address = a;
        #1;
        check(tag, bus4.readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        int   ones;
        int   dly;
        logic [2:0]  a;
        logic [31:0] wd;
        logic        cs;
        logic        wn;

        reset           = 1'b1;
        bus.address     = '0;
        bus.chipselect  = 1'b0;
        bus.write_n     = 1'b1;
        bus.writedata   = '0;
        bus4.address    = '0;
        bus4.chipselect = 1'b0;
        bus4.write_n    = 1'b1;
        bus4.writedata  = '0;

        // reset state
        do_reset(2);
        check("rst_out_const", 32'(out_port), 32'h2A5);
        rdc(3'd0, "rst_data", 32'h0000_02A5);
        rdc(3'd6, "rst_status", 32'h1);
        rdc(3'd1, "rst_blink_en", 32'h0);
        rdc(3'd2, "rst_period", 32'h0);

        // set / clear / toggle back-to-back
        step(1'b1, 1'b0, 3'd0, 32'h0);
        step(1'b1, 1'b0, 3'd3, 32'h0F0);
        check("set_out_lag", 32'(out_port), 32'h0);
        rdc(3'd0, "set_data", 32'h0F0);
        step(1'b1, 1'b0, 3'd4, 32'h030);
        check("clr_out_lag", 32'(out_port), 32'h0F0);
        rdc(3'd0, "clr_data", 32'h0C0);
        step(1'b1, 1'b0, 3'd5, 32'h3FF);
        check("tgl_out_lag", 32'(out_port), 32'h0C0);
        rdc(3'd0, "tgl_data", 32'h33F);
        idle();
        check("tgl_out", 32'(out_port), 32'h33F);
        rdc(3'd3, "rd_set_zero", 32'h0);
        rdc(3'd4, "rd_clr_zero", 32'h0);
        rdc(3'd5, "rd_tgl_zero", 32'h0);
        rdc(3'd7, "rd_rsvd_zero", 32'h0);

        // blink: DATA=3FF, BLINK_EN=1, PERIOD=3
        step(1'b1, 1'b0, 3'd0, 32'h3FF);
        step(1'b1, 1'b0, 3'd1, 32'h001);
        step(1'b1, 1'b0, 3'd2, 32'd3);
        rdc(3'd6, "blink_status_start", 32'h3);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            idle();
            check("blink_hi_bits", 32'(out_port[9:1]), 32'h1FF);
            if (i >= 2 && i < 10) ones += int'(out_port[0]);
            rd(3'd6, "blink_status");
        end
        check("blink_duty", ones, 4);

        // PERIOD rewrite in the cycle cnt reaches 0 with phase=1
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if ((m_age % (32'(m_p) + 32'd1)) == 32'(m_p) && m_phase()) found = 1'b1;
            else idle();
        end
        check("expiry_found", 32'(found), 32'h1);
        step(1'b1, 1'b0, 3'd2, 32'd5);
        rdc(3'd6, "rewrite_phase_held", 32'h3);
        dly = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            idle();
            dly++;
            bus.address = 3'd6;
            #1;
            if (bus.readdata[0] == 1'b0) found = 1'b1;
        end
        check("rewrite_toggle_delay", dly, 6);

        // randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 3) == 0);
            wd = $urandom;
            if (a == 3'd2 && $urandom_range(0, 7) != 0) wd = 32'($urandom_range(0, 6));
            if ($urandom_range(0, 59) == 0) do_reset(1);
            else step(cs, wn, a, wd);
            rd(3'($urandom_range(0, 7)), "rand_read");
        end

        // reset while blinking with phase = 0
        step(1'b1, 1'b0, 3'd0, 32'h3FF);
        step(1'b1, 1'b0, 3'd1, 32'h3FF);
        step(1'b1, 1'b0, 3'd2, 32'd2);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            idle();
            if (!m_phase()) found = 1'b1;
        end
        check("midrst_phase0_found", 32'(found), 32'h1);
        do_reset(1);
        check("midrst_out", 32'(out_port), 32'h2A5);
        rdc(3'd2, "midrst_period", 32'h0);
        rdc(3'd6, "midrst_status", 32'h1);
        for (int i = 0; i < 20; i++) begin
            idle();
            rdc(3'd6, "midrst_no_toggle", 32'h1);
        end

        // narrow instance: width masking and reserved address
        wr4(3'd0, 32'hFFFF_FFFF);
        rd4(3'd0, "w4_data_mask", 32'h0000_000F);
        wr4(3'd2, 32'h0000_01FF);
        rd4(3'd2, "w4_period_mask", 32'h0000_00FF);
        rd4(3'd6, "w4_status", 32'h3);
        wr4(3'd7, 32'hFFFF_FFFF);
        rd4(3'd7, "w4_rsvd_read", 32'h0);
        rd4(3'd0, "w4_data_kept", 32'h0000_000F);
        rd4(3'd1, "w4_en_kept", 32'h0);
        rd4(3'd2, "w4_period_kept", 32'h0000_00FF);
        check("w4_out", 32'(out_port4), 32'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_led_blink_pio.md
# cpu_led_blink_pio

Parametrised Avalon-MM output port for the CPU system, successor to the fixed 10-bit LED port. It provides a `WIDTH`-bit output register with atomic set/clear/toggle strobes and a per-bit hardware blink mode driven by a programmable prescaler. Software can flash status LEDs without polling. It sits on the CPU data master as a zero-wait-state slave and drives board LEDs or other static outputs.

## Interface
- `WIDTH`, 10: number of output bits, 1..32.
- `PRESC_W`, 24: width of the blink period register and counter, 1..32.
- `RESET_VALUE`, 0: `WIDTH`-bit reset value of DATA.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `address` input 3: word address of the register.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata` input 32: write data; bits at or above `WIDTH` (or `PRESC_W` for PERIOD) are ignored.
- `readdata` output 32: combinational read data, unused upper bits 0.
- `out_port` output `WIDTH`: registered output pins.

## Operation
Register map (word addresses):
- 0 DATA, RW: output value.
- 1 BLINK_EN, RW: per-bit blink enable, reset 0.
- 2 PERIOD, RW: prescaler reload `P`, reset 0.
- 3 SET, WO: `DATA <= DATA | wd`; reads 0.
- 4 CLEAR, WO: `DATA <= DATA & ~wd`; reads 0.
- 5 TOGGLE, WO: `DATA <= DATA ^ wd`; reads 0.
- 6 STATUS, RO: bit0 = `phase`, bit1 = `P != 0`; other bits 0.
- 7: reserved; reads 0, writes ignored.

Register writes:
- All writes update on the clock edge where the write is sampled.
- Writes to read-only or reserved addresses have no effect.

Blink engine:
- Internal down-counter `cnt` (`PRESC_W` bits) and a 1-bit `phase`.
- When `P == 0`: `cnt` is held at 0 and `phase` is held at 1, so blinking bits show DATA steadily.
- When `P != 0`, each cycle:
  - if `cnt == 0`: `cnt <= P` and `phase <= ~phase`;
  - else `cnt <= cnt - 1`.
- `phase` period is therefore `2*(P+1)` cycles, with 50 % duty.
- A write to PERIOD loads `cnt <= new P` and forces `phase <= 1` on the same edge. The write takes priority over an expiry in that cycle.

Output:
- `out_port <= DATA & ~(BLINK_EN & {WIDTH{~phase}})`, registered.
- Bits with BLINK_EN = 0 follow DATA.
- Bits with BLINK_EN = 1 show DATA while `phase = 1` and 0 while `phase = 0`.

Read path:
- `readdata` decodes `address` combinationally.
- It is independent of `chipselect`; the fabric qualifies it.

Reset (synchronous, `reset = 1` at an edge):
- DATA = `RESET_VALUE`, BLINK_EN = 0, PERIOD = 0.
- `cnt` = 0, `phase` = 1.
- `out_port` = `RESET_VALUE`.
- Reset has priority over any simultaneous write or counter activity.

## Timing
- Zero wait states. A write sampled at edge N updates the register at edge N; the `out_port` effect appears at edge N+1, one cycle of output latency.
- `readdata` reflects the register value after the edge; a read in the cycle after a write returns the new value.
- Read-modify-write via SET/CLEAR/TOGGLE is atomic within one cycle. There is no hazard with back-to-back strobes: each uses DATA as updated by the previous edge.
- First `phase` toggle after a PERIOD write at edge N occurs at edge N+P+1. `out_port` reflects it at N+P+2.
- Wrap-around: `cnt` never underflows; the reload occurs at 0.
- A reset asserted mid-blink returns `phase` to 1 on that edge. Blinking restarts only after PERIOD is rewritten.
- Changing BLINK_EN does not disturb `cnt` or `phase`.

## Test plan
- **Reset:** `RESET_VALUE = 10'h2A5`. Hold `reset` 2 cycles; then `out_port = 0x2A5`, `readdata` at address 0 = `0x000002A5`, STATUS = `0x1`.
- **Set/clear/toggle:** starting from DATA = 0, perform three back-to-back writes: SET `0x0F0`, CLEAR `0x030`, TOGGLE `0x3FF`.
  - DATA reads `0x0F0`, then `0x0C0`, then `0x33F`.
  - `out_port` lags each update by one cycle.
  - Reads of addresses 3–5 return 0.
- **Blink:** DATA = `0x3FF`, BLINK_EN = `0x001`, PERIOD = 3.
  - Bit 0 is 1 for 4 cycles and 0 for 4 cycles (8-cycle period).
  - Bits 9:1 stay 1.
  - STATUS bit0 tracks the same pattern.
- **PERIOD rewrite at expiry:** write PERIOD = 5 in the same cycle `cnt` reaches 0 with `phase = 1`.
  - `phase` stays 1.
  - Next toggle occurs 6 cycles later.
- **Width masking and reserved space:** with `WIDTH = 4`, `PRESC_W = 8`:
  - write DATA `0xFFFFFFFF` → reads `0x0000000F`;
  - write PERIOD `0x1FF` → reads `0xFF`;
  - write to address 7 → no register changes, reads 0.
- **Reset mid-operation:** assert `reset` while blinking with `phase = 0`.
  - Next cycle: `out_port = RESET_VALUE`, PERIOD = 0, `phase = 1`.
  - No further toggles occur.
